// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - load/store initiator for the word-organised data memory
//
// Purpose: accepts one load/store request at a time, performs byte/halfword/word
// access with little-endian lane selection, sign/zero extension and
// read-modify-write for sub-word stores, and reports alignment/range errors.
//
// Ports:
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   RequestValid/Ready    request handshake (Ready high only in IDLE)
//   RequestWrite          1 = store, 0 = load
//   RequestSize           00 byte, 01 halfword, 10 word, 11 illegal
//   RequestSigned         load sign-extend select
//   RequestAddress        byte address
//   RequestData           right-aligned store data
//   ResponseValid         one-cycle completion pulse
//   ResponseData          load result (0 for stores and errors)
//   ResponseError         error flag, qualified by ResponseValid
//   MemAddress            word address to memory, [1:0] always 0
//   MemDataIn             write data to memory
//   MemEnableWrite        memory write enable
//   MemDataOut            combinational read data from memory
module memory_access_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RequestValid,
  output logic        RequestReady,
  input  logic        RequestWrite,
  input  logic [1:0]  RequestSize,
  input  logic        RequestSigned,
  input  logic [31:0] RequestAddress,
  input  logic [31:0] RequestData,
  output logic        ResponseValid,
  output logic [31:0] ResponseData,
  output logic        ResponseError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemDataIn,
  output logic        MemEnableWrite,
  input  logic [31:0] MemDataOut
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  offset_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [31:0] data_q;

  logic        req_error;
  logic [4:0]  lane_shift;
  logic [31:0] lane_shifted;
  logic [31:0] load_value;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;

  // Ready is decoded from state only, so it never depends on Request* inputs.
  assign RequestReady = (state == IDLE);

  always_comb begin
    req_error = 1'b0;
    case (RequestSize)
      2'b01:   req_error = RequestAddress[0];
      2'b10:   req_error = |RequestAddress[1:0];
      2'b11:   req_error = 1'b1;
      default: req_error = 1'b0;
    endcase
    if (RequestAddress >= MEM_LIMIT) begin
      req_error = 1'b1;
    end
  end

  // Halfwords are always 2-byte aligned when they reach READ, so shifting by
  // the byte offset also selects the correct halfword lane.
  assign lane_shift   = {offset_q, 3'b000};
  assign lane_shifted = MemDataOut >> lane_shift;

  always_comb begin
    load_value = MemDataOut;
    case (size_q)
      2'b00: load_value = signed_q ? {{24{lane_shifted[7]}}, lane_shifted[7:0]}
                                   : {24'h000000, lane_shifted[7:0]};
      2'b01: load_value = signed_q ? {{16{lane_shifted[15]}}, lane_shifted[15:0]}
                                   : {16'h0000, lane_shifted[15:0]};
      default: load_value = MemDataOut;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes store data.
  assign lane_mask   = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign merged_word = (MemDataOut & ~lane_mask) | ((data_q << lane_shift) & lane_mask);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      offset_q       <= 2'b00;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      write_q        <= 1'b0;
      data_q         <= 32'h0;
      ResponseValid  <= 1'b0;
      ResponseData   <= 32'h0;
      ResponseError  <= 1'b0;
      MemAddress     <= 32'h0;
      MemDataIn      <= 32'h0;
      MemEnableWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ResponseValid  <= 1'b0;
          MemEnableWrite <= 1'b0;
          if (RequestValid) begin
            offset_q   <= RequestAddress[1:0];
            size_q     <= RequestSize;
            signed_q   <= RequestSigned;
            write_q    <= RequestWrite;
            data_q     <= RequestData;
            MemAddress <= {RequestAddress[31:2], 2'b00};
            if (req_error) begin
              ResponseValid <= 1'b1;
              ResponseError <= 1'b1;
              ResponseData  <= 32'h0;
              state         <= RESP;
            end else if (RequestWrite && (RequestSize == 2'b10)) begin
              MemDataIn      <= RequestData;
              MemEnableWrite <= 1'b1;
              state          <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            MemDataIn      <= merged_word;
            MemEnableWrite <= 1'b1;
            state          <= WRITE;
          end else begin
            ResponseValid <= 1'b1;
            ResponseError <= 1'b0;
            ResponseData  <= load_value;
            state         <= RESP;
          end
        end
        WRITE: begin
          MemEnableWrite <= 1'b0;
          ResponseValid  <= 1'b1;
          ResponseError  <= 1'b0;
          ResponseData   <= 32'h0;
          state          <= RESP;
        end
        RESP: begin
          ResponseValid <= 1'b0;
          ResponseError <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking bench for memory_access_unit
module tb_memory_access_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        RequestValid;
  logic        RequestReady;
  logic        RequestWrite;
  logic [1:0]  RequestSize;
  logic        RequestSigned;
  logic [31:0] RequestAddress;
  logic [31:0] RequestData;
  logic        ResponseValid;
  logic [31:0] ResponseData;
  logic        ResponseError;
  logic [31:0] MemAddress;
  logic [31:0] MemDataIn;
  logic        MemEnableWrite;
  logic [31:0] MemDataOut;

  memory_access_unit #(.MEM_BYTES(128)) dut (
    .Clock(Clock), .Reset(Reset),
    .RequestValid(RequestValid), .RequestReady(RequestReady),
    .RequestWrite(RequestWrite), .RequestSize(RequestSize),
    .RequestSigned(RequestSigned), .RequestAddress(RequestAddress),
    .RequestData(RequestData),
    .ResponseValid(ResponseValid), .ResponseData(ResponseData),
    .ResponseError(ResponseError),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemEnableWrite(MemEnableWrite), .MemDataOut(MemDataOut)
  );

  always #5 Clock = ~Clock;

  // Device memory: word organised, combinational read, synchronous write.
  logic [31:0] mem [0:31];
  int          wr_count = 0;
  logic [31:0] wr_addr, wr_data;
  assign MemDataOut = mem[MemAddress[6:2]];

  always @(posedge Clock) begin
    if (MemEnableWrite) begin
      wr_count++;
      wr_addr = MemAddress;
      wr_data = MemDataIn;
      mem[MemAddress[6:2]] <= MemDataIn;
    end
  end

  // Reference model: plain byte-addressed memory.
  logic [7:0] refm [0:127];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd128);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(refm[7'(a + 32'(i))]) << (8 * i));
    if (sg && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w = 0;
    for (int i = 0; i < 4; i++) w = w | (32'(refm[7'({a[6:2], 2'b00} + 32'(i))]) << (8 * i));
    return w;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) refm[7'(a + 32'(i))] = 8'(d >> (8 * i));
  endtask

  int          got_lat;
  logic [31:0] got_data;
  logic        got_err;
  logic        got_rv_after;
  int          got_nwr;

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    int wr_start;
    @(negedge Clock);
    RequestValid = 1'b1; RequestWrite = w; RequestSize = sz;
    RequestSigned = sg; RequestAddress = a; RequestData = d;
    chk("ready_idle", 32'(RequestReady), 32'd1);
    wr_start = wr_count;
    @(posedge Clock);
    #1;
    RequestValid = 1'b0;
    RequestAddress = $urandom(); RequestData = $urandom();
    RequestSize = 2'($urandom()); RequestWrite = 1'($urandom());
    got_lat = 0; got_data = 32'hX; got_err = 1'bX;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (ResponseValid) begin
        got_lat = k; got_data = ResponseData; got_err = ResponseError;
        break;
      end
    end
    @(negedge Clock);
    got_rv_after = ResponseValid;
    got_nwr = wr_count - wr_start;
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d);
    bit   e = model_err(sz, a);
    int   exp_lat = e ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
    logic [31:0] exp_data = (e || w) ? 32'h0 : model_load(sz, sg, a);
    run_req(w, sz, sg, a, d);
    chk({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(got_err), 32'(e));
    chk({tag, "_data"}, got_data, exp_data);
    chk({tag, "_single_pulse"}, 32'(got_rv_after), 32'd0);
    chk({tag, "_nwr"}, 32'(got_nwr), (w && !e) ? 32'd1 : 32'd0);
    if (w && !e) begin
      model_store(sz, a, d);
      chk({tag, "_waddr"}, wr_addr, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, wr_data, ref_word(a));
    end
  endtask

  initial begin
    int wr_start, first_rv, ready_at, lat;
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    logic        rw, rg;

    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'(i);
      for (int b = 0; b < 4; b++) refm[4 * i + b] = (b == 0) ? 8'(i) : 8'h00;
    end
    Reset = 1'b1; RequestValid = 1'b0; RequestWrite = 1'b0; RequestSize = 2'b00;
    RequestSigned = 1'b0; RequestAddress = 32'h0; RequestData = 32'h0;
    repeat (2) @(negedge Clock);
    chk("rst_ready", 32'(RequestReady), 32'd1);
    chk("rst_rvalid", 32'(ResponseValid), 32'd0);
    chk("rst_rerr", 32'(ResponseError), 32'd0);
    chk("rst_we", 32'(MemEnableWrite), 32'd0);
    chk("rst_rdata", ResponseData, 32'h0);
    chk("rst_maddr", MemAddress, 32'h0);
    chk("rst_mdin", MemDataIn, 32'h0);
    Reset = 1'b0;

    do_req("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    chk("tp_lw14", got_data, 32'h0000_0005);
    do_req("sb09", 1'b1, 2'b00, 1'b0, 32'h09, 32'h80);
    chk("tp_sb09_wdata", wr_data, 32'h0000_8002);
    chk("tp_sb09_waddr", wr_addr, 32'h0000_0008);
    do_req("lb09", 1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
    chk("tp_lb09", got_data, 32'hFFFF_FF80);
    do_req("lbu09", 1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    chk("tp_lbu09", got_data, 32'h0000_0080);
    do_req("sh0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'hBEEF);
    chk("tp_sh0e_wdata", wr_data, 32'hBEEF_0003);
    do_req("lh0e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0);
    chk("tp_lh0e", got_data, 32'hFFFF_BEEF);
    do_req("lhu0c", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0);
    chk("tp_lhu0c", got_data, 32'h0000_0003);
    do_req("lw16", 1'b0, 2'b10, 1'b0, 32'h16, 32'h0);
    do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    do_req("sw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h1234);
    do_req("lh7f", 1'b0, 2'b01, 1'b0, 32'h7F, 32'h0);
    do_req("sb7f", 1'b1, 2'b00, 1'b0, 32'h7F, 32'hA5);

    // Reset in the middle of the WRITE cycle of a word store.
    @(negedge Clock);
    RequestValid = 1'b1; RequestWrite = 1'b1; RequestSize = 2'b10;
    RequestAddress = 32'h20; RequestData = 32'hDEAD_BEEF;
    wr_start = wr_count;
    @(posedge Clock);
    #1;
    RequestValid = 1'b0;
    chk("rstw_we_in_write", 32'(MemEnableWrite), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("rstw_we_drop", 32'(MemEnableWrite), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    chk("rstw_ready", 32'(RequestReady), 32'd1);
    chk("rstw_nwr", 32'(wr_count - wr_start), 32'd0);
    do_req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("tp_lw20", got_data, 32'h0000_0008);

    // RequestValid held across two back-to-back requests.
    @(negedge Clock);
    RequestValid = 1'b1; RequestWrite = 1'b1; RequestSize = 2'b10;
    RequestSigned = 1'b0; RequestAddress = 32'h7C; RequestData = 32'h1234_5678;
    wr_start = wr_count;
    @(posedge Clock);
    #1;
    RequestWrite = 1'b0; RequestData = 32'h0;
    first_rv = 0; ready_at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      if (ResponseValid && first_rv == 0) first_rv = k;
      if (RequestReady) begin ready_at = k; break; end
    end
    chk("hold_first_lat", 32'(first_rv), 32'd2);
    chk("hold_ready_at", 32'(ready_at), 32'd3);
    @(posedge Clock);
    #1;
    RequestValid = 1'b0;
    lat = 0; got_data = 32'hX;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (ResponseValid) begin lat = k; got_data = ResponseData; break; end
    end
    model_store(2'b10, 32'h7C, 32'h1234_5678);
    chk("hold_lw_lat", 32'(lat), 32'd2);
    chk("hold_lw_data", got_data, 32'h1234_5678);
    chk("hold_nwr", 32'(wr_count - wr_start), 32'd1);

    // Randomised traffic against the byte-level model.
    for (int n = 0; n < 200; n++) begin
      rs = ($urandom_range(0, 9) < 3) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 9) rs = 2'b11;
      if ($urandom_range(0, 15) == 0) ra = $urandom();
      else ra = 32'($urandom_range(0, 135));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'b10) ra[1:0] = 2'b00;
        if (rs == 2'b01) ra[0] = 1'b0;
      end
      rw = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      rd = $urandom();
      do_req("rnd", rw, rs, rg, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the CPU datapath and drives the word-organised data memory.
- The memory has a combinational read port and a synchronous write port, selected by Address[6:2].
- Adds byte and halfword access, little-endian lane selection, sign/zero extension, and read-modify-write for sub-word stores.
- Reports alignment and range errors.

Parameters:
- MEM_BYTES, 128: memory size in bytes. Any access with address >= MEM_BYTES is an error.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- RequestValid  input  1  request present
- RequestReady  output  1  unit can accept a request (high only in IDLE)
- RequestWrite  input  1  1 = store, 0 = load
- RequestSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- RequestSigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- RequestAddress  input  32  byte address
- RequestData  input  32  store data, right-aligned
- ResponseValid  output  1  one-cycle completion pulse
- ResponseData  output  32  load result; 0 for stores and errors
- ResponseError  output  1  qualified by ResponseValid
- MemAddress  output  32  word address to memory, bits [1:0] always 0
- MemDataIn  output  32  write data to memory
- MemEnableWrite  output  1  memory write enable
- MemDataOut  input  32  combinational read data from memory

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - RequestReady=1; ResponseValid, ResponseError, MemEnableWrite = 0.
  - ResponseData, MemAddress, MemDataIn = 0.
  - Reset asserted in any state aborts the operation. MemEnableWrite falls immediately, so no write occurs on the next edge.
- States: IDLE, READ, WRITE, RESP. All outputs are registered or decoded from state only; no combinational path from Request* to Mem*.
- Accept: the handshake occurs at the edge where RequestValid && RequestReady. Address, size, signed, write flag and data are latched. MemAddress = {addr[31:2],2'b00}.
- Error check at accept. Any of the following is an error:
  - size 11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr >= MEM_BYTES
- Transitions from IDLE on accept:
  - error -> RESP with ResponseError=1
  - load -> READ
  - word store -> WRITE
  - byte/halfword store -> READ
  - Errors never enter WRITE.
- READ (one cycle): at the closing edge, MemDataOut is captured.
  - Load: extract the lane, extend per RequestSigned, write ResponseData, go to RESP.
  - Sub-word store: build merged word into MemDataIn, go to WRITE.
- Lanes (little-endian):
  - byte k = addr[1:0] occupies bits [8k+7:8k]
  - halfword h = addr[1] occupies bits [16h+15:16h]
  - Merge replaces only the addressed lane with the low bits of RequestData. Other lanes keep the captured value.
- WRITE (one cycle):
  - MemEnableWrite=1 for exactly this cycle; memory writes on the closing edge.
  - Word store uses MemDataIn = RequestData.
  - Next state is RESP.
- RESP (one cycle): ResponseValid=1, then return to IDLE. ResponseValid is never high two consecutive cycles.
- Latency, counted as cycles from the accept edge to the ResponseValid cycle:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Single outstanding request. RequestReady=0 in READ, WRITE and RESP. The next accept happens at the earliest in the IDLE cycle after RESP.
- Request* inputs are ignored outside IDLE.
- MemAddress and MemDataIn hold their last values in IDLE. MemEnableWrite=0 in all states except WRITE.

Test Plan (memory preloaded with word i = i):
- lw 0x14 -> ResponseValid 2 cycles after accept, ResponseData=0x00000005, ResponseError=0, MemEnableWrite never asserted.
- sb 0x80 to 0x09 -> READ of word 2, then a single WRITE of 0x00008002 with MemAddress=0x08. lb signed 0x09 -> 0xFFFFFF80; lbu 0x09 -> 0x00000080.
- sh 0xBEEF to 0x0E -> word 3 becomes 0xBEEF0003. lh signed 0x0E -> 0xFFFFBEEF; lhu 0x0C -> 0x00000003.
- lw 0x16, RequestSize=11 at 0x10, and sw at 0x80 -> each gives ResponseValid 1 cycle after accept, ResponseError=1, ResponseData=0, MemEnableWrite never high.
- Reset pulsed during the WRITE cycle of sw 0xDEADBEEF to 0x20 -> MemEnableWrite drops within the cycle, word 8 still reads 0x00000008, RequestReady=1 after reset release.
- RequestValid held high with sw 0x12345678 to 0x7C, then lw 0x7C -> second accept only in the IDLE cycle after the first ResponseValid. Load returns 0x12345678.
